bch_decoder: RTL

Serial decoder for the systematic BCH(63,56) SEC-DED code generated by g(x) = x^7 + x^6 + x^2 + 1, which equals (x+1)(x^6+x+1). It sits directly downstream of the encoder and consumes its 63-bit codeword: cw[62:39] is the 24-bit header, cw[38:7] is the 32-bit message m, and cw[6:0] is the parity. It computes the syndrome bit-serially, locates and corrects a single error with a 63-step search, and detects double errors. It returns the corrected message, a header check and error status.

---
 rtl/bch_pkg.sv | 23 ++
 rtl/bch_gf_mulx.sv | 12 +
 rtl/bch_decoder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bch_pkg.sv
// rtl/bch_pkg.sv - shared constants, field slices and FSM state type for the BCH(63,56) decoder
package bch_pkg;
  localparam int N     = 63;
  localparam int K     = 56;
  localparam int PAR   = 7;
  localparam int MSG_W = 32;
  localparam int HDR_W = K - MSG_W;

  localparam int MSG_LSB = PAR;
  localparam int MSG_MSB = PAR + MSG_W - 1;
  localparam int HDR_LSB = MSG_MSB + 1;
  localparam int HDR_MSB = N - 1;

  localparam logic [PAR-1:0]   G_LOW_DEF       = 7'h45;
  localparam logic [HDR_W-1:0] HDR_PATTERN_DEF = 24'h555555;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYND,
    ST_SEARCH,
    ST_DONE
  } state_e;
endpackage

// File: rtl/bch_gf_mulx.sv
// rtl/bch_gf_mulx.sv - multiply by x modulo g(x) with one bit shifted in at x^0
module bch_gf_mulx
  import bch_pkg::*;
#(
  parameter logic [PAR-1:0] G_LOW = G_LOW_DEF
) (
  input  logic [PAR-1:0] a_i,
  input  logic           b_i,
  output logic [PAR-1:0] y_o
);
  assign y_o = {a_i[PAR-2:0], b_i} ^ (a_i[PAR-1] ? G_LOW : '0);
endmodule

// File: rtl/bch_decoder.sv
// rtl/bch_decoder.sv - serial BCH(63,56) SEC-DED decoder: bit-serial syndrome, 63-step locator search
module bch_decoder
  import bch_pkg::*;
#(
  parameter logic [HDR_W-1:0] HDR_PATTERN = HDR_PATTERN_DEF,
  parameter logic [PAR-1:0]   G_LOW       = G_LOW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     cw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MSG_W-1:0] msg,
  output logic             hdr_ok,
  output logic             err_none,
  output logic             err_corr,
  output logic             err_uncorr,
  output logic [5:0]       err_pos
);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [N-1:0]     cw_q;
  logic [PAR-1:0]   syn_q;
  logic [PAR-1:0]   loc_q;
  logic [5:0]       cnt_q;
  logic [5:0]       pos_q;
  logic             found_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [MSG_W-1:0] msg_q;
  logic             hdr_ok_q;
  logic             none_q;
  logic             corr_q;
  logic             uncorr_q;
  logic [5:0]       err_pos_q;

  logic [PAR-1:0]   mulx_a;
  logic             mulx_b;
  logic [PAR-1:0]   mulx_y;
  logic             syn_zero_d;
  logic             corr_d;
  logic [N-1:0]     cw_fix_d;

  // One multiplier serves both phases: syndrome division in SYND, locator stepping in SEARCH.
  always_comb begin
    mulx_a = syn_q;
    mulx_b = 1'b0;
    if (state_q == ST_SEARCH) begin
      mulx_a = loc_q;
    end else if (state_q == ST_SYND) begin
      mulx_b = cw_q[6'd62 - cnt_q];
    end
  end

  bch_gf_mulx #(.G_LOW(G_LOW)) u_mulx (
    .a_i (mulx_a),
    .b_i (mulx_b),
    .y_o (mulx_y)
  );

  // Odd syndrome weight means odd received weight, since (x+1) divides g(x).
  always_comb begin
    syn_zero_d = (syn_q == '0);
    corr_d     = (^syn_q) & found_q;
    cw_fix_d   = cw_q ^ (corr_d ? (ONE << pos_q) : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cw_q        <= '0;
      syn_q       <= '0;
      loc_q       <= '0;
      cnt_q       <= '0;
      pos_q       <= '0;
      found_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      msg_q       <= '0;
      hdr_ok_q    <= 1'b0;
      none_q      <= 1'b0;
      corr_q      <= 1'b0;
      uncorr_q    <= 1'b0;
      err_pos_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            cw_q       <= cw;
            syn_q      <= '0;
            cnt_q      <= '0;
            pos_q      <= '0;
            found_q    <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= ST_SYND;
          end
        end
        ST_SYND: begin
          syn_q <= mulx_y;
          if (cnt_q == 6'd62) begin
            cnt_q   <= '0;
            loc_q   <= 7'h01;
            found_q <= 1'b0;
            state_q <= ST_SEARCH;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        ST_SEARCH: begin
          if ((loc_q == syn_q) && !found_q) begin
            found_q <= 1'b1;
            pos_q   <= cnt_q;
          end
          loc_q <= mulx_y;
          if (cnt_q == 6'd62) begin
            cnt_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        ST_DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            msg_q       <= cw_fix_d[MSG_MSB:MSG_LSB];
            hdr_ok_q    <= (cw_fix_d[HDR_MSB:HDR_LSB] == HDR_PATTERN);
            none_q      <= syn_zero_d;
            corr_q      <= corr_d;
            uncorr_q    <= !syn_zero_d && !corr_d;
            err_pos_q   <= corr_d ? pos_q : 6'd0;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            msg_q       <= '0;
            hdr_ok_q    <= 1'b0;
            none_q      <= 1'b0;
            corr_q      <= 1'b0;
            uncorr_q    <= 1'b0;
            err_pos_q   <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign msg        = msg_q;
  assign hdr_ok     = hdr_ok_q;
  assign err_none   = none_q;
  assign err_corr   = corr_q;
  assign err_uncorr = uncorr_q;
  assign err_pos    = err_pos_q;
endmodule
